// File: rtl/collision_pkg.sv
// Shared limits and invulnerability-counter types for the collision manager.
package collision_pkg;

   localparam int unsigned MAX_PLAYERS = 4;
   localparam int unsigned MAX_ENEMIES = 8;
   localparam int unsigned INV_CNT_W   = 8;

   typedef logic [INV_CNT_W-1:0] inv_cnt_t;

endpackage

// File: rtl/inv_timer.sv
// Per-player invulnerability frame counter: load on hit, count down once per frame.
module inv_timer
   import collision_pkg::*;
#(
   parameter int unsigned INV_FRAMES = 60
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 tick_i,
   input  logic                 load_i,
   output logic [INV_CNT_W-1:0] cnt_o
);

   inv_cnt_t cnt_q, cnt_d;

   // A load in the same frame tick as a decrement takes priority.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = inv_cnt_t'(INV_FRAMES);
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - inv_cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/collision_manager.sv
// Frame-level collision detection between players, enemies, bombs, blasts and scenery.
// Define FRIENDLY_FIRE_EN to let a player's own blast hit that player.
module collision_manager
   import collision_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned NUM_ENEMIES = 3,
   parameter int unsigned INV_FRAMES  = 60
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic [NUM_PLAYERS-1:0] dr_player,
   input  logic [NUM_PLAYERS-1:0] dr_bomb,
   input  logic [NUM_PLAYERS-1:0] dr_blast,
   input  logic [NUM_ENEMIES-1:0] dr_enemy,
   input  logic                   dr_columns,
   input  logic                   dr_wall,
   input  logic                   dr_spikes,
   input  logic                   dr_door,
   input  logic                   dr_powerup,
   output logic [NUM_PLAYERS-1:0] player_block,
   output logic [NUM_ENEMIES-1:0] enemy_block,
   output logic [NUM_PLAYERS-1:0] hit_pulse,
   output logic [NUM_PLAYERS-1:0] powerup_pulse,
   output logic [NUM_ENEMIES-1:0] kill_pulse,
   output logic                   door_pulse,
   output logic [NUM_PLAYERS-1:0] player_invulnerable,
   output logic                   blast_wall_pix
);

   logic any_bomb, any_blast, any_enemy, any_player;
   logic other_bomb, other_blast, blast_hits;

   logic [NUM_PLAYERS-1:0] pblock_pix, hit_pix, pwr_pix;
   logic [NUM_ENEMIES-1:0] eblock_pix, kill_pix;
   logic                   door_pix;

   logic [NUM_PLAYERS-1:0] acc_pblock_q, acc_pblock_d;
   logic [NUM_PLAYERS-1:0] acc_hit_q, acc_hit_d;
   logic [NUM_PLAYERS-1:0] acc_pwr_q, acc_pwr_d;
   logic [NUM_ENEMIES-1:0] acc_eblock_q, acc_eblock_d;
   logic [NUM_ENEMIES-1:0] acc_kill_q, acc_kill_d;
   logic                   acc_door_q, acc_door_d;

   logic [NUM_PLAYERS-1:0] player_block_q, player_block_d;
   logic [NUM_ENEMIES-1:0] enemy_block_q, enemy_block_d;
   logic [NUM_PLAYERS-1:0] hit_pulse_q, hit_pulse_d;
   logic [NUM_PLAYERS-1:0] powerup_pulse_q, powerup_pulse_d;
   logic [NUM_ENEMIES-1:0] kill_pulse_q, kill_pulse_d;
   logic                   door_pulse_q, door_pulse_d;

   logic [INV_CNT_W-1:0]   inv_cnt [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] inv_active;

   // Per-pixel collision conditions.
   always_comb begin
      any_bomb    = |dr_bomb;
      any_blast   = |dr_blast;
      any_enemy   = |dr_enemy;
      any_player  = |dr_player;
      other_bomb  = 1'b0;
      other_blast = 1'b0;
      blast_hits  = 1'b0;
      pblock_pix  = '0;
      hit_pix     = '0;
      pwr_pix     = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
         other_bomb  = 1'b0;
         other_blast = 1'b0;
         for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
            if (q != p) begin
               other_bomb  = other_bomb | dr_bomb[q];
               other_blast = other_blast | dr_blast[q];
            end
         end
`ifdef FRIENDLY_FIRE_EN
         blast_hits = other_blast | dr_blast[p];
`else
         blast_hits = other_blast;
`endif
         pblock_pix[p] = dr_player[p] & (dr_columns | dr_wall | other_bomb);
         hit_pix[p]    = dr_player[p] & (blast_hits | any_enemy | dr_spikes);
         pwr_pix[p]    = dr_player[p] & dr_powerup;
      end
      eblock_pix = dr_enemy & {NUM_ENEMIES{dr_columns | dr_wall | any_bomb}};
      kill_pix   = dr_enemy & {NUM_ENEMIES{any_blast}};
      door_pix   = any_player & dr_door & ~dr_wall;
   end

   assign blast_wall_pix = any_blast & dr_wall & ~dr_columns;

   // On startOfFrame the accumulators restart from the current pixel, so that
   // cycle belongs to the new frame, while the old contents go to the outputs.
   always_comb begin
      player_block_d  = player_block_q;
      enemy_block_d   = enemy_block_q;
      hit_pulse_d     = '0;
      powerup_pulse_d = '0;
      kill_pulse_d    = '0;
      door_pulse_d    = 1'b0;
      acc_pblock_d    = acc_pblock_q | pblock_pix;
      acc_hit_d       = acc_hit_q | hit_pix;
      acc_pwr_d       = acc_pwr_q | pwr_pix;
      acc_eblock_d    = acc_eblock_q | eblock_pix;
      acc_kill_d      = acc_kill_q | kill_pix;
      acc_door_d      = acc_door_q | door_pix;
      if (startOfFrame) begin
         player_block_d  = acc_pblock_q;
         enemy_block_d   = acc_eblock_q;
         hit_pulse_d     = acc_hit_q & ~inv_active;
         powerup_pulse_d = acc_pwr_q;
         kill_pulse_d    = acc_kill_q;
         door_pulse_d    = acc_door_q;
         acc_pblock_d    = pblock_pix;
         acc_hit_d       = hit_pix;
         acc_pwr_d       = pwr_pix;
         acc_eblock_d    = eblock_pix;
         acc_kill_d      = kill_pix;
         acc_door_d      = door_pix;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         acc_pblock_q    <= '0;
         acc_hit_q       <= '0;
         acc_pwr_q       <= '0;
         acc_eblock_q    <= '0;
         acc_kill_q      <= '0;
         acc_door_q      <= 1'b0;
         player_block_q  <= '0;
         enemy_block_q   <= '0;
         hit_pulse_q     <= '0;
         powerup_pulse_q <= '0;
         kill_pulse_q    <= '0;
         door_pulse_q    <= 1'b0;
      end else begin
         acc_pblock_q    <= acc_pblock_d;
         acc_hit_q       <= acc_hit_d;
         acc_pwr_q       <= acc_pwr_d;
         acc_eblock_q    <= acc_eblock_d;
         acc_kill_q      <= acc_kill_d;
         acc_door_q      <= acc_door_d;
         player_block_q  <= player_block_d;
         enemy_block_q   <= enemy_block_d;
         hit_pulse_q     <= hit_pulse_d;
         powerup_pulse_q <= powerup_pulse_d;
         kill_pulse_q    <= kill_pulse_d;
         door_pulse_q    <= door_pulse_d;
      end
   end

   // The counter loads on the same edge that raises hit_pulse.
   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_inv
      inv_timer #(
         .INV_FRAMES(INV_FRAMES)
      ) u_inv_timer (
         .clk   (clk),
         .resetN(resetN),
         .tick_i(startOfFrame),
         .load_i(hit_pulse_d[p]),
         .cnt_o (inv_cnt[p])
      );
      assign inv_active[p] = (inv_cnt[p] != '0);
   end

   assign player_block        = player_block_q;
   assign enemy_block         = enemy_block_q;
   assign hit_pulse           = hit_pulse_q;
   assign powerup_pulse       = powerup_pulse_q;
   assign kill_pulse          = kill_pulse_q;
   assign door_pulse          = door_pulse_q;
   assign player_invulnerable = inv_active;

endmodule

// File: tb/tb_collision_manager.sv
// Randomized and directed bench for collision_manager against a frame-level reference model.
module tb_collision_manager;

   localparam int NP  = 2;
   localparam int NE  = 3;
   localparam int INV = 60;

   logic          clk = 1'b0;
   logic          resetN = 1'b0;
   logic          startOfFrame = 1'b0;
   logic [NP-1:0] dr_player = '0, dr_bomb = '0, dr_blast = '0;
   logic [NE-1:0] dr_enemy = '0;
   logic          dr_columns = 0, dr_wall = 0, dr_spikes = 0, dr_door = 0, dr_powerup = 0;

   logic [NP-1:0] player_block, hit_pulse, powerup_pulse, player_invulnerable;
   logic [NE-1:0] enemy_block, kill_pulse;
   logic          door_pulse, blast_wall_pix;

   int tests = 0;
   int fails = 0;

   // Reference model state: what each frame has seen so far, and frames of invulnerability left.
   bit [NP-1:0] m_seen_pb, m_seen_hit, m_seen_pw;
   bit [NE-1:0] m_seen_eb, m_seen_kill;
   bit          m_seen_door;
   int          m_inv [NP];
   bit [NP-1:0] e_pb, e_hit, e_pw;
   bit [NE-1:0] e_eb, e_kill;
   bit          e_door;

   collision_manager #(
      .NUM_PLAYERS(NP),
      .NUM_ENEMIES(NE),
      .INV_FRAMES (INV)
   ) dut (
      .clk                (clk),
      .resetN             (resetN),
      .startOfFrame       (startOfFrame),
      .dr_player          (dr_player),
      .dr_bomb            (dr_bomb),
      .dr_blast           (dr_blast),
      .dr_enemy           (dr_enemy),
      .dr_columns         (dr_columns),
      .dr_wall            (dr_wall),
      .dr_spikes          (dr_spikes),
      .dr_door            (dr_door),
      .dr_powerup         (dr_powerup),
      .player_block       (player_block),
      .enemy_block        (enemy_block),
      .hit_pulse          (hit_pulse),
      .powerup_pulse      (powerup_pulse),
      .kill_pulse         (kill_pulse),
      .door_pulse         (door_pulse),
      .player_invulnerable(player_invulnerable),
      .blast_wall_pix     (blast_wall_pix)
   );

   always #5 clk = ~clk;

   function automatic bit [14:0] all_outputs();
      return {player_block, enemy_block, hit_pulse, powerup_pulse, kill_pulse, door_pulse,
              player_invulnerable};
   endfunction

   task automatic clear_inputs();
      dr_player = '0; dr_bomb = '0; dr_blast = '0; dr_enemy = '0;
      dr_columns = 0; dr_wall = 0; dr_spikes = 0; dr_door = 0; dr_powerup = 0;
   endtask

   task automatic model_reset();
      m_seen_pb = '0; m_seen_hit = '0; m_seen_pw = '0; m_seen_eb = '0; m_seen_kill = '0;
      m_seen_door = 0;
      e_pb = '0; e_hit = '0; e_pw = '0; e_eb = '0; e_kill = '0; e_door = 0;
      for (int p = 0; p < NP; p++) m_inv[p] = 0;
   endtask

   // Advance one clock with the currently driven pixel inputs; model predicts every output.
   task automatic step(input bit sof);
      bit [NP-1:0] px_pb, px_hit, px_pw;
      bit [NE-1:0] px_eb, px_kill;
      bit          px_door, exp_bwp, bomb_other, blast_hurts;
      bit [NP-1:0] e_inv;
      bit [14:0]   expv;
      startOfFrame = sof;
      #1;
      exp_bwp = (dr_blast != 0) && dr_wall && !dr_columns;
      tests++;
      if (blast_wall_pix !== exp_bwp) begin
         fails++;
         $display("FAIL blast_wall_pix t=%0t got %b want %b", $time, blast_wall_pix, exp_bwp);
      end
      for (int p = 0; p < NP; p++) begin
         bomb_other  = 0;
         blast_hurts = 0;
         for (int q = 0; q < NP; q++) begin
            if (q != p && dr_bomb[q]) bomb_other = 1;
`ifdef FRIENDLY_FIRE_EN
            if (dr_blast[q]) blast_hurts = 1;
`else
            if (q != p && dr_blast[q]) blast_hurts = 1;
`endif
         end
         px_pb[p]  = dr_player[p] && (dr_columns || dr_wall || bomb_other);
         px_hit[p] = dr_player[p] && (blast_hurts || dr_enemy != 0 || dr_spikes);
         px_pw[p]  = dr_player[p] && dr_powerup;
      end
      for (int k = 0; k < NE; k++) begin
         px_eb[k]   = dr_enemy[k] && (dr_columns || dr_wall || dr_bomb != 0);
         px_kill[k] = dr_enemy[k] && (dr_blast != 0);
      end
      px_door = (dr_player != 0) && dr_door && !dr_wall;
      if (sof) begin
         e_pb = m_seen_pb; e_eb = m_seen_eb; e_pw = m_seen_pw;
         e_kill = m_seen_kill; e_door = m_seen_door;
         for (int p = 0; p < NP; p++) begin
            e_hit[p] = m_seen_hit[p] && (m_inv[p] == 0);
            if (e_hit[p]) m_inv[p] = INV;
            else if (m_inv[p] > 0) m_inv[p] = m_inv[p] - 1;
         end
         m_seen_pb = px_pb; m_seen_hit = px_hit; m_seen_pw = px_pw;
         m_seen_eb = px_eb; m_seen_kill = px_kill; m_seen_door = px_door;
      end else begin
         e_hit = '0; e_pw = '0; e_kill = '0; e_door = 0;
         m_seen_pb |= px_pb; m_seen_hit |= px_hit; m_seen_pw |= px_pw;
         m_seen_eb |= px_eb; m_seen_kill |= px_kill; m_seen_door |= px_door;
      end
      @(posedge clk);
      #1;
      startOfFrame = 0;
      for (int p = 0; p < NP; p++) e_inv[p] = (m_inv[p] != 0);
      expv = {e_pb, e_eb, e_hit, e_pw, e_kill, e_door, e_inv};
      tests++;
      if (all_outputs() !== expv) begin
         fails++;
         $display("FAIL outputs t=%0t got %b want %b", $time, all_outputs(), expv);
      end
   endtask

   task automatic do_reset(input int cycles);
      resetN = 0;
      #1;
      model_reset();
      tests++;
      if (all_outputs() !== 15'd0) begin
         fails++;
         $display("FAIL reset_outputs got %b want 0", all_outputs());
      end
      repeat (cycles) @(posedge clk);
      #1;
      resetN = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      do_reset(3);
      step(0);
      step(0);
      tests++;
      if (all_outputs() !== 15'd0) begin
         fails++;
         $display("FAIL post_reset_idle got %b want 0", all_outputs());
      end
   endtask

   task automatic test_block();
      do_reset(2);
      step(1);
      dr_player = 2'b01; dr_columns = 1;
      repeat (10) step(0);
      clear_inputs();
      repeat (3) step(0);
      step(1);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (player_block[0] !== 1'b1) begin
            fails++;
            $display("FAIL block_hold cyc=%0d got %b want 1", i, player_block[0]);
         end
         step(0);
      end
      step(1);
      tests++;
      if (player_block[0] !== 1'b0) begin
         fails++;
         $display("FAIL block_clear got %b want 0", player_block[0]);
      end
   endtask

   task automatic test_hit_invuln();
      int pulses = 0;
      bit hit_frame, exp_inv;
      do_reset(2);
      step(1);
      dr_player = 2'b01; dr_enemy = 3'b010;
      repeat (500) step(0);
      clear_inputs();
      step(1);
      tests++;
      if (hit_pulse[0] !== 1'b1 || player_invulnerable[0] !== 1'b1) begin
         fails++;
         $display("FAIL first_hit got pulse=%b inv=%b want 1 1", hit_pulse[0],
                  player_invulnerable[0]);
      end
      for (int k = 1; k <= 61; k++) begin
         hit_frame = (k >= 2 && k <= 59) || (k == 61);
         if (hit_frame) begin
            dr_player = 2'b01; dr_spikes = 1;
         end
         step(0);
         step(0);
         clear_inputs();
         step(0);
         step(1);
         if (hit_pulse[0] === 1'b1) pulses++;
         exp_inv = (k <= 59) || (k == 61);
         tests++;
         if (hit_pulse[0] !== (k == 61) || player_invulnerable[0] !== exp_inv) begin
            fails++;
            $display("FAIL invuln_frame%0d got pulse=%b inv=%b want %b %b", k, hit_pulse[0],
                     player_invulnerable[0], (k == 61), exp_inv);
         end
      end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL invuln_pulse_count got %0d want 1", pulses);
      end
   endtask

   task automatic test_friendly_fire();
      bit exp_own;
`ifdef FRIENDLY_FIRE_EN
      exp_own = 1;
`else
      exp_own = 0;
`endif
      do_reset(2);
      step(1);
      dr_player = 2'b01; dr_blast = 2'b01;
      repeat (3) step(0);
      clear_inputs();
      step(1);
      tests++;
      if (hit_pulse !== {1'b0, exp_own}) begin
         fails++;
         $display("FAIL own_blast got %b want %b", hit_pulse, {1'b0, exp_own});
      end
      do_reset(2);
      step(1);
      dr_player = 2'b01; dr_blast = 2'b10;
      repeat (3) step(0);
      clear_inputs();
      step(1);
      tests++;
      if (hit_pulse !== 2'b01) begin
         fails++;
         $display("FAIL other_blast got %b want 01", hit_pulse);
      end
   endtask

   task automatic test_blast_wall();
      clear_inputs();
      dr_blast = 2'b10; dr_wall = 1;
      #1;
      tests++;
      if (blast_wall_pix !== 1'b1) begin
         fails++;
         $display("FAIL bwp_wall got %b want 1", blast_wall_pix);
      end
      dr_columns = 1;
      #1;
      tests++;
      if (blast_wall_pix !== 1'b0) begin
         fails++;
         $display("FAIL bwp_columns got %b want 0", blast_wall_pix);
      end
      clear_inputs();
      step(0);
   endtask

   task automatic test_back_to_back();
      do_reset(2);
      step(1);
      dr_player = 2'b01; dr_columns = 1;
      repeat (3) step(0);
      dr_player = 2'b10;
      step(1);
      tests++;
      if (player_block !== 2'b01) begin
         fails++;
         $display("FAIL b2b_first got %b want 01", player_block);
      end
      clear_inputs();
      step(1);
      tests++;
      if (player_block !== 2'b10) begin
         fails++;
         $display("FAIL b2b_second got %b want 10", player_block);
      end
      step(1);
      tests++;
      if (player_block !== 2'b00) begin
         fails++;
         $display("FAIL b2b_third got %b want 00", player_block);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      step(1);
      dr_enemy = 3'b100; dr_blast = 2'b01; dr_wall = 1;
      repeat (4) step(0);
      resetN = 0;
      #1;
      model_reset();
      tests++;
      if (all_outputs() !== 15'd0 || blast_wall_pix !== 1'b1) begin
         fails++;
         $display("FAIL mid_reset got %b bwp=%b want 0 bwp=1", all_outputs(), blast_wall_pix);
      end
      repeat (3) @(posedge clk);
      #1;
      resetN = 1;
      clear_inputs();
      step(0);
      step(0);
      step(1);
      tests++;
      if (kill_pulse !== 3'b000 || all_outputs() !== 15'd0) begin
         fails++;
         $display("FAIL mid_reset_snap got kill=%b out=%b want 0", kill_pulse, all_outputs());
      end
   endtask

   task automatic test_random();
      int len;
      do_reset(2);
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, 10);
         for (int c = 0; c <= len; c++) begin
            dr_player  = NP'($urandom);
            dr_bomb    = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
            dr_blast   = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
            dr_enemy   = ($urandom_range(0, 2) == 0) ? NE'($urandom) : '0;
            dr_columns = ($urandom_range(0, 5) == 0);
            dr_wall    = ($urandom_range(0, 4) == 0);
            dr_spikes  = ($urandom_range(0, 7) == 0);
            dr_door    = ($urandom_range(0, 3) == 0);
            dr_powerup = ($urandom_range(0, 3) == 0);
            step(c == 0);
         end
      end
      clear_inputs();
      step(1);
      step(0);
   endtask

   initial begin
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_block();
      test_hit_invuln();
      test_friendly_fire();
      test_blast_wall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
